step_button_conditioner: RTL

STEP_BUTTON_CONDITIONER -- requirements
Module: step_button_conditioner

---
 rtl/step_button_pkg.sv | 20 ++
 rtl/debounce_sync.sv | 45 ++++
 rtl/step_button_conditioner.sv | 134 +++++++++++++
 3 files changed

// File: rtl/step_button_pkg.sv
// rtl/step_button_pkg.sv - shared FSM state type, parameter defaults and counter sizing helper
package step_button_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int HOLD_CYCLES_DEF     = 32;
   localparam int REPEAT_CYCLES_DEF   = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HELD    = 2'd1,
      ST_REPEAT  = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   // A parameter of 1 still needs a one-bit counter
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchroniser followed by a run-length debouncer
module debounce_sync
   import step_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int             W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [W-1:0]   TERM = W'(DEBOUNCE_CYCLES - 1);

   logic         s1;
   logic         s2;
   logic [W-1:0] run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // run counts consecutive disagreeing samples; it tops out exactly at the accept point
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run   <= '0;
         level <= 1'b0;
      end else if (s2 == level) begin
         run <= '0;
      end else if (run == TERM) begin
         level <= s2;
         run   <= '0;
      end else begin
         run <= run + W'(1);
      end
   end

endmodule

// File: rtl/step_button_conditioner.sv
// rtl/step_button_conditioner.sv - turns two raw up/down buttons into step/ud pulses with auto-repeat
module step_button_conditioner
   import step_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up,
   input  logic btn_dn,
   output logic step,
   output logic ud
);

   localparam int              HW    = cnt_width(HOLD_CYCLES);
   localparam int              RW    = cnt_width(REPEAT_CYCLES);
   localparam logic [HW-1:0]   HTERM = HW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0]   RTERM = RW'(REPEAT_CYCLES - 1);

   logic          up_lvl;
   logic          dn_lvl;
   logic          up_prev;
   logic          dn_prev;
   logic          up_rise;
   logic          dn_rise;
   logic          act_lvl;
   logic          oth_lvl;
   state_t        state;
   state_t        state_nx;
   logic          step_nx;
   logic          ud_nx;
   logic          cnt_clr;
   logic [HW-1:0] hold_cnt;
   logic [RW-1:0] rep_cnt;

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_up),
      .level (up_lvl)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_dn),
      .level (dn_lvl)
   );

   assign up_rise = up_lvl & ~up_prev;
   assign dn_rise = dn_lvl & ~dn_prev;
   // ud remembers which button owns the current press
   assign act_lvl = ud ? dn_lvl : up_lvl;
   assign oth_lvl = ud ? up_lvl : dn_lvl;

   always_comb begin
      state_nx = state;
      step_nx  = 1'b0;
      ud_nx    = ud;
      cnt_clr  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (up_lvl && dn_lvl) begin
               state_nx = ST_LOCKOUT;
            end else if (up_rise) begin
               step_nx  = 1'b1;
               ud_nx    = 1'b0;
               state_nx = ST_HELD;
               cnt_clr  = 1'b1;
            end else if (dn_rise) begin
               step_nx  = 1'b1;
               ud_nx    = 1'b1;
               state_nx = ST_HELD;
               cnt_clr  = 1'b1;
            end
         end
         ST_HELD: begin
            if (oth_lvl) begin
               state_nx = ST_LOCKOUT;
            end else if (!act_lvl) begin
               state_nx = ST_IDLE;
            end else if (hold_cnt == HTERM && !step) begin
               step_nx  = 1'b1;
               state_nx = ST_REPEAT;
               cnt_clr  = 1'b1;
            end
         end
         ST_REPEAT: begin
            if (oth_lvl) begin
               state_nx = ST_LOCKOUT;
            end else if (!act_lvl) begin
               state_nx = ST_IDLE;
            end else if (rep_cnt == RTERM && !step) begin
               step_nx = 1'b1;
               cnt_clr = 1'b1;
            end
         end
         ST_LOCKOUT: begin
            if (!up_lvl && !dn_lvl) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         step     <= 1'b0;
         ud       <= 1'b0;
         up_prev  <= 1'b0;
         dn_prev  <= 1'b0;
         hold_cnt <= '0;
         rep_cnt  <= '0;
      end else begin
         state   <= state_nx;
         step    <= step_nx;
         ud      <= ud_nx;
         up_prev <= up_lvl;
         dn_prev <= dn_lvl;
         // each interval counter only runs in its own state and sticks at its terminal count
         if (cnt_clr || state != ST_HELD)
            hold_cnt <= '0;
         else if (hold_cnt != HTERM)
            hold_cnt <= hold_cnt + HW'(1);
         if (cnt_clr || state != ST_REPEAT)
            rep_cnt <= '0;
         else if (rep_cnt != RTERM)
            rep_cnt <= rep_cnt + RW'(1);
      end
   end

endmodule
